// File: rtl/matrix_pkg.sv
// Shared types and defaults for the systolic matrix result drain.
// Optional column-major streaming: MATRIX_DRAIN_COL_MAJOR_EN.
package matrix_pkg;

   localparam int N_DEF   = 3;
   localparam int W_DEF   = 8;
   localparam int LAT_DEF = 10;
   localparam int IDX_W   = $clog2(N_DEF);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } state_t;

endpackage

// File: rtl/matrix_idx_counter.sv
// Row/column walker over an N x N result matrix with last-element detect.
// MATRIX_DRAIN_COL_MAJOR_EN selects column-major order (row-major otherwise).
module matrix_idx_counter
   import matrix_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = IDX_W
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          clr,
   input  logic          adv,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic          last
);

   localparam logic [IW-1:0] MAX = IW'(N - 1);

   // Step to the next element on each accepted beat, wrapping the fast index.
   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         row <= '0;
         col <= '0;
      end else if (adv) begin
`ifdef MATRIX_DRAIN_COL_MAJOR_EN
         if (row == MAX) begin
            row <= '0;
            col <= (col == MAX) ? '0 : col + 1'b1;
         end else begin
            row <= row + 1'b1;
         end
`else
         if (col == MAX) begin
            col <= '0;
            row <= (row == MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
`endif
      end
   end

   // The final element is (N-1, N-1) in either order.
   always_comb begin
      last = (row == MAX) && (col == MAX);
   end

endmodule

// File: rtl/matrix_result_drain.sv
// Drains the N x N accumulator array: wait LAT, snapshot, stream per beat.
// MATRIX_DRAIN_COL_MAJOR_EN switches the stream to column-major order.
module matrix_result_drain
   import matrix_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int W   = W_DEF,
   parameter int LAT = LAT_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic [N*N*W-1:0]     acc_in,
   output logic                 acc_clr,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_row,
   output logic [$clog2(N)-1:0] out_col,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam int IW = $clog2(N);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] LOAD = CW'(LAT - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_nxt;
   logic [N*N*W-1:0]   snap;
   logic               snap_en;
   logic               idx_clr;
   logic               xfer;
   logic               last;
   logic [IW-1:0]      row;
   logic [IW-1:0]      col;

   matrix_idx_counter #(
      .N  (N),
      .IW (IW)
   ) u_idx (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (idx_clr),
      .adv  (xfer),
      .row  (row),
      .col  (col),
      .last (last)
   );

   // Next-state, wait countdown and the accumulator clear pulse.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_clr   = 1'b0;
      snap_en   = 1'b0;
      idx_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = WAIT;
               cnt_nxt   = LOAD;
               acc_clr   = 1'b1;
            end
         end
         WAIT: begin
            cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
            if (cnt <= CW'(1)) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            snap_en   = 1'b1;
            idx_clr   = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            if (xfer && last) begin
               if (start) begin
                  state_nxt = WAIT;
                  cnt_nxt   = LOAD;
                  acc_clr   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (RST) begin
         acc_clr = 1'b0;
      end
   end

   // State, counter, snapshot and the done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         snap  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= xfer && last;
         if (snap_en) begin
            snap <= acc_in;
         end
      end
   end

   // Stream outputs are zero outside SEND so idle outputs stay quiet.
   always_comb begin
      out_valid = (state == SEND);
      busy      = (state != IDLE);
      xfer      = out_valid && out_ready;
      out_last  = out_valid && last;
      out_row   = out_valid ? row : '0;
      out_col   = out_valid ? col : '0;
      out_data  = '0;
      if (out_valid) begin
         out_data = snap[(int'(row) * N + int'(col)) * W +: W];
      end
   end

endmodule
